// File: rtl/fetch_decode_queue.sv
// In-order instruction queue between fetch and decode. The head entry falls
// through to the outputs; entries from a stale fetch epoch are discarded at the head.
module fetch_decode_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             flush,
  input  logic             cur_token,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [163:0]     enq_data,
  output logic             deq_valid,
  input  logic             deq_ready,
  output logic [163:0]     deq_data,
  output logic [CNT_W-1:0] count,
  output logic             stale_drop
);

  localparam int PTR_W     = $clog2(DEPTH);
  // Entry layout: {valid, token, mal_insn, fault_insn, pc, pc4, instr, prediction, badaddr}
  localparam int VALID_BIT = 163;
  localparam int TOKEN_BIT = 162;

  logic [163:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_stale_drop;

  logic [163:0]     w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_head_stale;
  logic             w_enq_fire;
  logic             w_deq_valid;
  logic             w_deq_fire;
  logic             w_stale_pop;
  logic             w_pop;
  logic [CNT_W-1:0] w_count_next;

  assign w_head       = r_mem[r_rd_ptr];
  assign w_full       = (r_count == CNT_W'(DEPTH));
  assign w_empty      = (r_count == '0);
  assign w_head_stale = (w_head[TOKEN_BIT] != cur_token);

  // enq_ready depends only on registered occupancy, so a full queue stays closed
  // even while decode is draining it this cycle.
  assign w_enq_fire   = enq_valid & ~w_full & enq_data[VALID_BIT] & ~flush;
  assign w_deq_valid  = ~w_empty & ~w_head_stale & ~flush;
  assign w_deq_fire   = w_deq_valid & deq_ready;
  assign w_stale_pop  = ~w_empty & w_head_stale & ~flush;
  assign w_pop        = w_deq_fire | w_stale_pop;
  assign w_count_next = r_count + CNT_W'(w_enq_fire) - CNT_W'(w_pop);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_stale_drop <= 1'b0;
    end else if (flush) begin
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_stale_drop <= 1'b0;
    end else begin
      if (w_enq_fire) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count      <= w_count_next;
      r_stale_drop <= w_stale_pop;
    end
  end

  // Storage carries no reset: contents are only observed behind a nonzero count.
  always_ff @(posedge CLK) begin
    if (w_enq_fire) begin
      r_mem[r_wr_ptr] <= enq_data;
    end
  end

  assign enq_ready  = ~w_full;
  assign deq_valid  = w_deq_valid;
  assign deq_data   = w_head;
  assign count      = r_count;
  assign stale_drop = r_stale_drop;

endmodule
